// File: rtl/seqdet_pkg.sv
// Shared types and elaboration-time KMP next-state helpers for seq_detector_param.
// Config macro: SEQDET_MATCH_COUNT_EN (enables the match counter).
package seqdet_pkg;

    localparam int SEQDET_MAX_LEN = 16;
    localparam int STATE_W        = $clog2(SEQDET_MAX_LEN + 1);

    typedef logic [STATE_W-1:0] state_t;

    // Pattern bit j in arrival order (j = 0 is the first bit received).
    function automatic logic pat_bit(input logic [SEQDET_MAX_LEN-1:0] pattern,
                                     input int len, input int j);
        logic [SEQDET_MAX_LEN-1:0] sh;
        sh = pattern >> (len - 1 - j);
        return sh[0];
    endfunction

    // Longest proper border of the full pattern.
    function automatic int seqdet_border(input logic [SEQDET_MAX_LEN-1:0] pattern,
                                         input int len);
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k < len; k++) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++) begin
                if (pat_bit(pattern, len, len - k + m) != pat_bit(pattern, len, m)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    function automatic state_t seqdet_next(input logic [SEQDET_MAX_LEN-1:0] pattern,
                                           input int len, input bit overlap,
                                           input state_t state, input logic b);
        int  cur;
        int  best;
        int  p;
        bit  ok;
        logic wb;
        if (int'(state) > len) return '0;
        cur = int'(state);
        if (cur == len) cur = overlap ? seqdet_border(pattern, len) : 0;
        // Window is the matched prefix of length cur followed by b.
        best = 0;
        for (int k = 1; k <= cur + 1; k++) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++) begin
                p  = cur + 1 - k + m;
                wb = (p < cur) ? pat_bit(pattern, len, p) : b;
                if (wb != pat_bit(pattern, len, m)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return state_t'(best);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-input bundle for seq_detector_param; counter signals exist only with SEQDET_MATCH_COUNT_EN.
// Handshake: in is consumed on a rising clk edge only while in_valid is high; no backpressure.
interface seq_detector_param_if
    import seqdet_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic   in;
    logic   in_valid;
    logic   q;
    state_t state;
`ifdef SEQDET_MATCH_COUNT_EN
    logic             match_clr;
    logic [CNT_W-1:0] match_count;

    modport master (output in, in_valid, match_clr, input q, state, match_count);
    modport slave  (input in, in_valid, match_clr, output q, state, match_count);
`else
    modport master (output in, in_valid, input q, state);
    modport slave  (input in, in_valid, output q, state);
`endif
endinterface

// File: rtl/seqdet_match_counter.sv
// Saturating match counter; synchronous clear wins over a simultaneous increment.
module seqdet_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)                       count_d = '0;
        else if (inc_i && count_q != '1) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with elaboration-time KMP next-state table.
// Config macro: SEQDET_MATCH_COUNT_EN adds match_clr/match_count and the saturating counter.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                   PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN   = 4'b1010,
    parameter bit                   OVERLAP     = 1'b1,
    parameter int                   CNT_W       = 8
) (
    input logic                  clk,
    input logic                  reset,
    seq_detector_param_if.slave  bus
);
    localparam logic [SEQDET_MAX_LEN-1:0] PAT_EXT = SEQDET_MAX_LEN'(PATTERN);
    localparam state_t ACCEPT   = state_t'(PATTERN_LEN);
    localparam int     N_STATES = 1 << STATE_W;

    // Indexed by {state, bit}; unreachable state codes fall back to S0.
    state_t nxt_tbl [2*N_STATES];
    state_t state_q, state_d;

    for (genvar s = 0; s < N_STATES; s++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam state_t NXT = seqdet_next(PAT_EXT, PATTERN_LEN, OVERLAP,
                                                 state_t'(s), 1'(b));
            assign nxt_tbl[2*s+b] = NXT;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.in_valid) state_d = nxt_tbl[{state_q, bus.in}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= '0;
        else       state_q <= state_d;
    end

    assign bus.q     = (state_q == ACCEPT);
    assign bus.state = state_q;

`ifdef SEQDET_MATCH_COUNT_EN
    seqdet_match_counter #(.CNT_W(CNT_W)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (bus.match_clr),
        .inc_i   (bus.in_valid && (state_d == ACCEPT)),
        .count_o (bus.match_count)
    );
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param over several pattern/overlap configurations.
// Counter checks are active when SEQDET_MATCH_COUNT_EN is defined.
module tb_seq_detector_param;
    import seqdet_pkg::*;

    logic clk;
    logic reset;
    logic din;
    logic dvalid;
    logic dclr;
    int   sel;
    int   n_checks;
    int   n_errors;

    // a: 1010 ovl, b: 1010 non-ovl, c: 11011 ovl, d: 1010 ovl CNT_W=2, e: len 1 pattern 1 non-ovl
    seq_detector_param_if #(.CNT_W(8)) if_a ();
    seq_detector_param_if #(.CNT_W(8)) if_b ();
    seq_detector_param_if #(.CNT_W(8)) if_c ();
    seq_detector_param_if #(.CNT_W(2)) if_d ();
    seq_detector_param_if #(.CNT_W(8)) if_e ();

    assign if_a.in = din;  assign if_a.in_valid = dvalid && (sel == 0);
    assign if_b.in = din;  assign if_b.in_valid = dvalid && (sel == 1);
    assign if_c.in = din;  assign if_c.in_valid = dvalid && (sel == 2);
    assign if_d.in = din;  assign if_d.in_valid = dvalid && (sel == 3);
    assign if_e.in = din;  assign if_e.in_valid = dvalid && (sel == 4);
`ifdef SEQDET_MATCH_COUNT_EN
    assign if_a.match_clr = dclr && (sel == 0);
    assign if_b.match_clr = dclr && (sel == 1);
    assign if_c.match_clr = dclr && (sel == 2);
    assign if_d.match_clr = dclr && (sel == 3);
    assign if_e.match_clr = dclr && (sel == 4);
`endif

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    seq_detector_param #(.PATTERN_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(8))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));
    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2))
        dut_d (.clk(clk), .reset(reset), .bus(if_d));
    seq_detector_param #(.PATTERN_LEN(1), .PATTERN(1'b1), .OVERLAP(1'b0), .CNT_W(8))
        dut_e (.clk(clk), .reset(reset), .bus(if_e));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic get_q(input int s);
        case (s)
            0: return if_a.q;
            1: return if_b.q;
            2: return if_c.q;
            3: return if_d.q;
            default: return if_e.q;
        endcase
    endfunction

`ifdef SEQDET_MATCH_COUNT_EN
    function automatic logic [31:0] get_cnt(input int s);
        case (s)
            0: return 32'(if_a.match_count);
            1: return 32'(if_b.match_count);
            2: return 32'(if_c.match_count);
            3: return 32'(if_d.match_count);
            default: return 32'(if_e.match_count);
        endcase
    endfunction
`endif

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input int s, input logic b, input logic clr);
        @(negedge clk);
        sel = s; din = b; dvalid = 1'b1; dclr = clr;
        @(posedge clk);
        #1;
        dvalid = 1'b0; dclr = 1'b0;
    endtask

    task automatic stall(input int s);
        @(negedge clk);
        sel = s; din = 1'($urandom_range(0, 1)); dvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Sends n bits (MSB first) and checks q after each against qexp (MSB first).
    task automatic run_seq(input int s, input int n, input logic [15:0] bits,
                           input logic [15:0] qexp, input string tag);
        for (int i = 0; i < n; i++) begin
            send(s, 1'(bits >> (n - 1 - i)), 1'b0);
            check($sformatf("%s_q_b%0d", tag, i + 1), 32'(get_q(s)), 32'(1'(qexp >> (n - 1 - i))));
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b0; din = 1'b0; dvalid = 1'b0; dclr = 1'b0; sel = 0;
        do_reset();

        for (int s = 0; s < 5; s++) begin
            check($sformatf("reset_q_%0d", s), 32'(get_q(s)), 32'd0);
`ifdef SEQDET_MATCH_COUNT_EN
            check($sformatf("reset_cnt_%0d", s), get_cnt(s), 32'd0);
`endif
        end

        // 1010 overlapping
        run_seq(0, 6, 16'b101010, 16'b000101, "a_ovl");
`ifdef SEQDET_MATCH_COUNT_EN
        check("a_ovl_cnt", get_cnt(0), 32'd2);
`endif

        // 1010 non-overlapping
        run_seq(1, 8, 16'b10101010, 16'b00010001, "b_novl");
`ifdef SEQDET_MATCH_COUNT_EN
        check("b_novl_cnt", get_cnt(1), 32'd2);
`endif

        // 11011 overlapping, then failure path from S2 on '1'
        run_seq(2, 8, 16'b11011011, 16'b00001001, "c_ovl");
        do_reset();
        run_seq(2, 6, 16'b111011, 16'b000001, "c_fail");

        // single-bit pattern re-accepts with OVERLAP=0
        run_seq(4, 4, 16'b1101, 16'b1101, "e_len1");

        // stall mid-pattern and in ACCEPT
        do_reset();
        run_seq(0, 2, 16'b10, 16'b00, "stall_pre");
        for (int i = 0; i < 3; i++) begin
            stall(0);
            check("stall_mid_q", 32'(if_a.q), 32'd0);
            check("stall_mid_state", 32'(if_a.state), 32'd2);
        end
        run_seq(0, 2, 16'b10, 16'b01, "stall_post");
        for (int i = 0; i < 3; i++) begin
            stall(0);
            check("stall_acc_q", 32'(if_a.q), 32'd1);
            check("stall_acc_state", 32'(if_a.state), 32'd4);
`ifdef SEQDET_MATCH_COUNT_EN
            check("stall_acc_cnt", get_cnt(0), 32'd1);
`endif
        end

        // asynchronous reset mid-pattern
        run_seq(0, 5, 16'b00101, 16'b00000, "rst_pre");
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_q", 32'(if_a.q), 32'd0);
        check("async_rst_state", 32'(if_a.state), 32'd0);
`ifdef SEQDET_MATCH_COUNT_EN
        check("async_rst_cnt", get_cnt(0), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        run_seq(0, 1, 16'b0, 16'b0, "rst_tail0");
        run_seq(0, 4, 16'b1010, 16'b0001, "rst_fresh");
`ifdef SEQDET_MATCH_COUNT_EN
        check("rst_fresh_cnt", get_cnt(0), 32'd1);
`endif

        // CNT_W=2 saturation and clear priority
        run_seq(3, 4, 16'b1010, 16'b0001, "sat1");
`ifdef SEQDET_MATCH_COUNT_EN
        check("sat_cnt1", get_cnt(3), 32'd1);
`endif
        run_seq(3, 4, 16'b1010, 16'b0101, "sat2");
`ifdef SEQDET_MATCH_COUNT_EN
        check("sat_cnt3", get_cnt(3), 32'd3);
`endif
        run_seq(3, 4, 16'b1010, 16'b0101, "sat3");
`ifdef SEQDET_MATCH_COUNT_EN
        check("sat_cnt5", get_cnt(3), 32'd3);
`endif
        send(3, 1'b1, 1'b0);
        send(3, 1'b0, 1'b1);
        check("clr_match_q", 32'(if_d.q), 32'd1);
`ifdef SEQDET_MATCH_COUNT_EN
        check("clr_match_cnt", get_cnt(3), 32'd0);
`endif
        run_seq(3, 2, 16'b10, 16'b01, "post_clr");
`ifdef SEQDET_MATCH_COUNT_EN
        check("post_clr_cnt", get_cnt(3), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
